stream_delay_adjust: RTL

- Per-channel variable delay element, placed between split_stream and the per-channel axi_fifo buffers in the I/Q delay RFNoC block. One instance is used for I and one for Q.
- Applies a programmable integer-sample delay to an AXI-Stream without a delay FIFO.
- Increasing the delay inserts zero samples; decreasing it drops input samples.
- Output is registered, and packet boundaries are preserved or synthesised.

---
 rtl/stream_delay_adjust.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/stream_delay_adjust.sv
// Variable integer-sample delay on an AXI-Stream with no delay FIFO: raising the
// delay injects zero samples, lowering it discards input samples.
module stream_delay_adjust #(
    parameter int WIDTH        = 16,
    parameter int MAX_LEN_LOG2 = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [WIDTH-1:0]        i_tdata,
    input  logic                    i_tlast,
    input  logic                    i_tvalid,
    output logic                    i_tready,
    output logic [WIDTH-1:0]        o_tdata,
    output logic                    o_tlast,
    output logic                    o_tvalid,
    input  logic                    o_tready,
    input  logic [MAX_LEN_LOG2-1:0] len,
    input  logic [15:0]             max_spp,
    output logic [MAX_LEN_LOG2-1:0] cur_len,
    output logic [31:0]             insert_cnt,
    output logic [31:0]             drop_cnt
);

    typedef enum logic [1:0] {
        MODE_PASS   = 2'd0,
        MODE_INSERT = 2'd1,
        MODE_DROP   = 2'd2
    } mode_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        if (v == 32'hFFFF_FFFF) begin
            return v;
        end else begin
            return v + 32'd1;
        end
    endfunction

    logic [WIDTH-1:0]        o_tdata_q, o_tdata_d;
    logic                    o_tlast_q, o_tlast_d;
    logic                    o_tvalid_q, o_tvalid_d;
    logic [MAX_LEN_LOG2-1:0] cur_len_q, cur_len_d;
    logic [31:0]             insert_cnt_q, insert_cnt_d;
    logic [31:0]             drop_cnt_q, drop_cnt_d;
    logic                    pending_tlast_q, pending_tlast_d;
    logic [15:0]             run_cnt_q, run_cnt_d;

    mode_t                   mode_s;
    logic                    load_en_s;
    logic                    i_tready_s;
    logic [MAX_LEN_LOG2-1:0] cur_len_inc_s;
    logic                    ins_last_s;

    // Mode decode and next-state for the output register, delay and counters
    always_comb begin
        o_tdata_d       = o_tdata_q;
        o_tlast_d       = o_tlast_q;
        o_tvalid_d      = o_tvalid_q;
        cur_len_d       = cur_len_q;
        insert_cnt_d    = insert_cnt_q;
        drop_cnt_d      = drop_cnt_q;
        pending_tlast_d = pending_tlast_q;
        run_cnt_d       = run_cnt_q;
        i_tready_s      = 1'b0;

        if (len > cur_len_q) begin
            mode_s = MODE_INSERT;
        end else if (len < cur_len_q) begin
            mode_s = MODE_DROP;
        end else begin
            mode_s = MODE_PASS;
        end

        load_en_s     = !o_tvalid_q || o_tready;
        cur_len_inc_s = cur_len_q + MAX_LEN_LOG2'(1);
        // An inserted run ends at the target delay or at the packet-size limit
        ins_last_s    = (cur_len_inc_s == len) ||
                        ((max_spp != 16'd0) && (run_cnt_q == (max_spp - 16'd1)));

        case (mode_s)
            MODE_PASS: begin
                i_tready_s = load_en_s;
                run_cnt_d  = 16'd0;
                if (load_en_s) begin
                    if (i_tvalid) begin
                        o_tdata_d       = i_tdata;
                        o_tlast_d       = i_tlast | pending_tlast_q;
                        o_tvalid_d      = 1'b1;
                        pending_tlast_d = 1'b0;
                    end else begin
                        o_tvalid_d = 1'b0;
                    end
                end else begin
                    o_tvalid_d = o_tvalid_q;
                end
            end
            MODE_INSERT: begin
                i_tready_s = 1'b0;
                if (load_en_s) begin
                    o_tdata_d    = WIDTH'(0);
                    o_tlast_d    = ins_last_s;
                    o_tvalid_d   = 1'b1;
                    cur_len_d    = cur_len_inc_s;
                    insert_cnt_d = sat_inc(insert_cnt_q);
                    run_cnt_d    = ins_last_s ? 16'd0 : (run_cnt_q + 16'd1);
                end else begin
                    run_cnt_d = run_cnt_q;
                end
            end
            MODE_DROP: begin
                i_tready_s = 1'b1;
                run_cnt_d  = 16'd0;
                if (o_tvalid_q && o_tready) begin
                    o_tvalid_d = 1'b0;
                end else begin
                    o_tvalid_d = o_tvalid_q;
                end
                if (i_tvalid) begin
                    cur_len_d       = cur_len_q - MAX_LEN_LOG2'(1);
                    drop_cnt_d      = sat_inc(drop_cnt_q);
                    pending_tlast_d = pending_tlast_q | i_tlast;
                end else begin
                    pending_tlast_d = pending_tlast_q;
                end
            end
            default: begin
                i_tready_s = 1'b0;
            end
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            o_tdata_q       <= WIDTH'(0);
            o_tlast_q       <= 1'b0;
            o_tvalid_q      <= 1'b0;
            cur_len_q       <= MAX_LEN_LOG2'(0);
            insert_cnt_q    <= 32'd0;
            drop_cnt_q      <= 32'd0;
            pending_tlast_q <= 1'b0;
            run_cnt_q       <= 16'd0;
        end else begin
            o_tdata_q       <= o_tdata_d;
            o_tlast_q       <= o_tlast_d;
            o_tvalid_q      <= o_tvalid_d;
            cur_len_q       <= cur_len_d;
            insert_cnt_q    <= insert_cnt_d;
            drop_cnt_q      <= drop_cnt_d;
            pending_tlast_q <= pending_tlast_d;
            run_cnt_q       <= run_cnt_d;
        end
    end

    assign i_tready   = i_tready_s;
    assign o_tdata    = o_tdata_q;
    assign o_tlast    = o_tlast_q;
    assign o_tvalid   = o_tvalid_q;
    assign cur_len    = cur_len_q;
    assign insert_cnt = insert_cnt_q;
    assign drop_cnt   = drop_cnt_q;

endmodule
